// File: rtl/exc_pkg.sv
// Shared exception-pipeline definitions: ExcCodes, stage record, fetch window.
// Optional EXC_BADVADDR_EN adds a bad-address field to every stage.
package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] DEF_ADDR_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_ADDR_HI  = 32'h0000_4ffc;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] pc;
  } exc_stage_t;

endpackage

// File: rtl/exc_stage.sv
// One exception-tracking pipeline register with merge, stall and flush.
// EXC_BADVADDR_EN adds the badvaddr field alongside code.
module exc_stage
  import exc_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              CODE_W   = 5,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              upStall,
  input  logic              inValid,
  input  logic              inExc,
  input  logic [CODE_W-1:0] inCode,
  input  logic              inBd,
  input  logic [PC_W-1:0]   inPc,
`ifdef EXC_BADVADDR_EN
  input  logic [PC_W-1:0]   inBadv,
  input  logic [PC_W-1:0]   reqAddr,
  output logic [PC_W-1:0]   badv,
`endif
  input  logic              req,
  input  logic [CODE_W-1:0] reqCode,
  output logic              valid,
  output logic              exc,
  output logic [CODE_W-1:0] code,
  output logic              bd,
  output logic [PC_W-1:0]   pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      exc   <= 1'b0;
      code  <= '0;
      bd    <= 1'b0;
      pc    <= RESET_PC;
`ifdef EXC_BADVADDR_EN
      badv  <= '0;
`endif
    end else if (flush) begin
      // bubble keeps a usable pc for EPC
      valid <= 1'b0;
      exc   <= 1'b0;
      code  <= '0;
      bd    <= 1'b0;
      pc    <= (inPc != '0) ? inPc : pc;
`ifdef EXC_BADVADDR_EN
      badv  <= '0;
`endif
    end else if (stall) begin
      if (req && !exc) begin
        exc  <= 1'b1;
        code <= reqCode;
`ifdef EXC_BADVADDR_EN
        badv <= reqAddr;
`endif
      end
    end else if (upStall) begin
      valid <= 1'b0;
      exc   <= 1'b0;
      code  <= '0;
      bd    <= 1'b0;
`ifdef EXC_BADVADDR_EN
      badv  <= '0;
`endif
    end else begin
      valid <= inValid;
      exc   <= inExc;
      code  <= inCode;
      bd    <= inBd;
      pc    <= inPc;
`ifdef EXC_BADVADDR_EN
      badv  <= inBadv;
`endif
    end
  end

endmodule

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline from Decode to commit, driving CP0 outputs.
// EXC_BADVADDR_EN adds exc_addr input and out_badvaddr output.
module exc_pipe
  import exc_pkg::*;
#(
  parameter int                STAGES    = 3,
  parameter int                PC_W      = 32,
  parameter int                CODE_W    = 5,
  parameter logic [PC_W-1:0]   ADDR_LO   = PC_W'(DEF_ADDR_LO),
  parameter logic [PC_W-1:0]   ADDR_HI   = PC_W'(DEF_ADDR_HI),
  parameter logic [PC_W-1:0]   RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [CODE_W-1:0] CODE_ADEL = CODE_W'(EXC_ADEL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     in_bd,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic [STAGES-1:0]        exc_req,
  input  logic [STAGES*CODE_W-1:0] exc_code,
`ifdef EXC_BADVADDR_EN
  input  logic [STAGES*PC_W-1:0]   exc_addr,
  output logic [PC_W-1:0]          out_badvaddr,
`endif
  output logic                     out_valid,
  output logic                     out_exc,
  output logic [CODE_W-1:0]        out_code,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_bd,
  output logic [PC_W-1:0]          out_epc
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] sValid, sExc, sBd;
  logic [STAGES-1:0] nValid, nExc, nBd;
  logic [STAGES-1:0] upStall;
  logic [CODE_W-1:0] sCode [STAGES];
  logic [CODE_W-1:0] nCode [STAGES];
  logic [PC_W-1:0]   sPc   [STAGES];
  logic [PC_W-1:0]   nPc   [STAGES];
`ifdef EXC_BADVADDR_EN
  logic [PC_W-1:0]   sBadv [STAGES];
  logic [PC_W-1:0]   nBadv [STAGES];
`endif

  logic fetchFault;

  assign fetchFault = in_valid &&
                      ((in_pc < ADDR_LO) ||
                       (in_pc > ADDR_HI) ||
                       (in_pc[1:0] != 2'b00));

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign nValid[i]  = in_valid;
      assign nExc[i]    = fetchFault;
      assign nCode[i]   = fetchFault ? CODE_ADEL : '0;
      assign nBd[i]     = in_bd;
      assign nPc[i]     = in_pc;
      assign upStall[i] = 1'b0;
`ifdef EXC_BADVADDR_EN
      assign nBadv[i]   = fetchFault ? in_pc : '0;
`endif
    end else begin : g_body
      logic take;
      // request for stage i-1 rides along as it advances
      assign take = exc_req[i-1] && !flush[i-1] && !sExc[i-1];
      assign nValid[i]  = sValid[i-1];
      assign nExc[i]    = sExc[i-1] | take;
      assign nCode[i]   = take ? exc_code[(i-1)*CODE_W +: CODE_W]
                               : sCode[i-1];
      assign nBd[i]     = sBd[i-1];
      assign nPc[i]     = sPc[i-1];
      assign upStall[i] = stall[i-1];
`ifdef EXC_BADVADDR_EN
      assign nBadv[i]   = take ? exc_addr[(i-1)*PC_W +: PC_W]
                               : sBadv[i-1];
`endif
    end

    exc_stage #(
      .PC_W     (PC_W),
      .CODE_W   (CODE_W),
      .RESET_PC (RESET_PC)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall[i]),
      .flush   (flush[i]),
      .upStall (upStall[i]),
      .inValid (nValid[i]),
      .inExc   (nExc[i]),
      .inCode  (nCode[i]),
      .inBd    (nBd[i]),
      .inPc    (nPc[i]),
`ifdef EXC_BADVADDR_EN
      .inBadv  (nBadv[i]),
      .reqAddr (exc_addr[i*PC_W +: PC_W]),
      .badv    (sBadv[i]),
`endif
      .req     (exc_req[i]),
      .reqCode (exc_code[i*CODE_W +: CODE_W]),
      .valid   (sValid[i]),
      .exc     (sExc[i]),
      .code    (sCode[i]),
      .bd      (sBd[i]),
      .pc      (sPc[i])
    );
  end

  assign out_valid = sValid[LAST];
  assign out_exc   = sExc[LAST];
  assign out_code  = sExc[LAST] ? sCode[LAST] : '0;
  assign out_pc    = sPc[LAST];
  assign out_bd    = sBd[LAST];
  assign out_epc   = out_bd ? out_pc - PC_W'(4) : out_pc;
`ifdef EXC_BADVADDR_EN
  assign out_badvaddr = sBadv[LAST];
`endif

endmodule

// File: tb/tb_exc_pipe.sv
// Directed bench for exc_pipe: vector table plus stall/flush/reset sequences.
// Build with EXC_BADVADDR_EN to hook up the optional ports.
module tb_exc_pipe;

  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_bd = 1'b0;
  logic [31:0]   in_pc = 32'h3000;
  logic [ST-1:0] stall = '0;
  logic [ST-1:0] flush = '0;
  logic [ST-1:0] exc_req = '0;
  logic [ST*5-1:0] exc_code = '0;
`ifdef EXC_BADVADDR_EN
  logic [ST*32-1:0] exc_addr = '0;
  logic [31:0]      out_badvaddr;
`endif
  logic        out_valid, out_exc, out_bd;
  logic [4:0]  out_code;
  logic [31:0] out_pc, out_epc;

  int checks = 0;
  int failures = 0;

  exc_pipe #(.STAGES(ST)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_bd    (in_bd),
    .stall    (stall),
    .flush    (flush),
    .exc_req  (exc_req),
    .exc_code (exc_code),
`ifdef EXC_BADVADDR_EN
    .exc_addr     (exc_addr),
    .out_badvaddr (out_badvaddr),
`endif
    .out_valid (out_valid),
    .out_exc   (out_exc),
    .out_code  (out_code),
    .out_pc    (out_pc),
    .out_bd    (out_bd),
    .out_epc   (out_epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic        r0;
    logic [4:0]  c0;
    logic        r1;
    logic [4:0]  c1;
    logic        eExc;
    logic [4:0]  eCode;
    logic [31:0] eEpc;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic v, input logic e,
                     input logic [4:0] c, input logic b,
                     input logic [31:0] p, input logic [31:0] ep);
    logic [71:0] act, exp;
    act = {out_valid, out_exc, out_code, out_bd, out_pc, out_epc};
    exp = {v, e, c, b, p, ep};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b e=%b c=%0d bd=%b pc=%h epc=%h want v=%b e=%b c=%0d bd=%b pc=%h epc=%h",
               nm, out_valid, out_exc, out_code, out_bd, out_pc, out_epc,
               v, e, c, b, p, ep);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h3000, 0, 0, 0,  0, 0,  0, 0,  32'h3000};
    vecs[1] = '{32'h3002, 0, 0, 0,  0, 0,  1, 4,  32'h3002};
    vecs[2] = '{32'h5000, 0, 0, 0,  0, 0,  1, 4,  32'h5000};
    vecs[3] = '{32'h3008, 0, 1, 10, 1, 12, 1, 10, 32'h3008};
    vecs[4] = '{32'h3010, 1, 0, 0,  1, 12, 1, 12, 32'h300c};
    vecs[5] = '{32'h2ffc, 0, 0, 0,  0, 0,  1, 4,  32'h2ffc};
    vecs[6] = '{32'h4ffc, 0, 0, 0,  0, 0,  0, 0,  32'h4ffc};
    vecs[7] = '{32'h3002, 0, 1, 10, 0, 0,  1, 4,  32'h3002};
    vecs[8] = '{32'h4ffc, 1, 1, 8,  0, 0,  1, 8,  32'h4ff8};

    step();
    step();
    chk("reset", 0, 0, 0, 0, 32'h3000, 32'h3000);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_pc    = vecs[i].pc;
      in_bd    = vecs[i].bd;
      step();
      in_valid = 1'b0;
      in_bd    = 1'b0;
      exc_req[0]    = vecs[i].r0;
      exc_code[4:0] = vecs[i].c0;
      step();
      exc_req       = '0;
      exc_code      = '0;
      exc_req[1]    = vecs[i].r1;
      exc_code[9:5] = vecs[i].c1;
      step();
      exc_req  = '0;
      exc_code = '0;
      chk($sformatf("vec%0d", i), 1'b1, vecs[i].eExc, vecs[i].eCode,
          vecs[i].bd, vecs[i].pc, vecs[i].eEpc);
    end

    // stall stage 0 for two cycles: two bubbles reach the output
    doReset();
    in_valid = 1'b1;
    in_pc    = 32'h3004;
    step();
    in_valid = 1'b0;
    stall[0] = 1'b1;
    step();
    step();
    chk("stall_bub1", 0, 0, 0, 0, 32'h3000, 32'h3000);
    stall = '0;
    step();
    chk("stall_bub2", 0, 0, 0, 0, 32'h3000, 32'h3000);
    step();
    chk("stall_rel", 1, 0, 0, 0, 32'h3004, 32'h3004);

    // flush with same-cycle request: request dropped, bubble keeps pc
    doReset();
    in_valid = 1'b1;
    in_pc    = 32'h3020;
    step();
    in_valid = 1'b0;
    in_pc    = 32'h3024;
    step();
    flush[1]      = 1'b1;
    exc_req[1]    = 1'b1;
    exc_code[9:5] = 5'd12;
    step();
    flush    = '0;
    exc_req  = '0;
    exc_code = '0;
    chk("flush_drop", 1, 0, 0, 0, 32'h3020, 32'h3020);
    step();
    chk("flush_bub", 0, 0, 0, 0, 32'h3024, 32'h3024);

    // request into a stalled stage is recorded in place
    doReset();
    in_valid = 1'b1;
    in_pc    = 32'h3030;
    step();
    in_valid = 1'b0;
    step();
    stall[1]      = 1'b1;
    exc_req[1]    = 1'b1;
    exc_code[9:5] = 5'd12;
    step();
    chk("stmerge_bub", 0, 0, 0, 0, 32'h3000, 32'h3000);
    stall    = '0;
    exc_req  = '0;
    exc_code = '0;
    step();
    chk("stmerge_out", 1, 1, 12, 0, 32'h3030, 32'h3030);

    // reset wins over stall
    stall = '1;
    reset = 1'b1;
    step();
    chk("reset_stall", 0, 0, 0, 0, 32'h3000, 32'h3000);
    reset = 1'b0;
    stall = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
